core_sequencer: RTL
===================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: start  in  1  begin or resume execution; level sampled per cycle.
REQ-004 SHALL have: halt_req  in  1  request to stop at the next instruction boundary.
REQ-005 SHALL have: opcode  in  7  instruction[6:0] from the instruction register.
REQ-006 SHALL have: imem_rdy  in  1  instruction memory data valid; dmem_rdy  in  1  data memory access complete.
REQ-007 SHALL have: cu_prf_wr_en  in  1, cu_data_mem_wr_en  in  1, branch_taken  in  1  raw control_unit outputs.
REQ-008 SHALL have: imem_req  out  1, ir_ld  out  1  (instruction register load), dmem_req  out  1.
REQ-009 SHALL have: prf_wr_en  out  1, data_mem_wr_en  out  1, pc_wr_en  out  1, pc_sel_branch  out  1  (gated datapath strobes).
REQ-010 SHALL have: busy  out  1, halted  out  1, illegal  out  1, state  out  3, instr_cnt  out  32  (retired-instruction count).

Function
REQ-011 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT; outputs are Moore, except that ir_ld and the MEM/WRITEBACK strobes are gated by the current-cycle inputs named below.
REQ-012 IDLE: all strobes 0; start=1 -> FETCH.
REQ-013 FETCH: imem_req=1; hold while imem_rdy=0; on imem_rdy=1, ir_ld=1 in the same cycle -> DECODE.
REQ-014 DECODE: one cycle; opcode not in {OPCODE_I_TYPE, OPCODE_R_TYPE, OPCODE_B_TYPE, OPCODE_J_TYPE, 7'b0000011, 7'b0100011} -> HALT with illegal=1; else -> EXECUTE.
REQ-015 EXECUTE: one cycle; load or store opcode -> MEM; otherwise -> WRITEBACK.
REQ-016 MEM: dmem_req=1, data_mem_wr_en=cu_data_mem_wr_en; hold until dmem_rdy=1 -> WRITEBACK.
REQ-017 WRITEBACK: one cycle; prf_wr_en=cu_prf_wr_en, pc_wr_en=1, pc_sel_branch=branch_taken; instr_cnt increments by 1.
REQ-018 After WRITEBACK: halt pending -> HALT; otherwise -> FETCH.
REQ-019 prf_wr_en, data_mem_wr_en, pc_wr_en SHALL never assert outside WRITEBACK/MEM; at most one PRF write per instruction.
REQ-020 Latency with imem_rdy held high: 4 cycles per non-memory instruction; load/store takes 5 cycles plus dmem_rdy wait cycles.
REQ-021 halt_req=1 in any non-IDLE cycle SHALL set a sticky pending flag; the flag clears on entry to HALT; halt_req is ignored in IDLE and HALT.
REQ-022 Simultaneous start and halt_req in IDLE: start wins, the pending flag is set, and exactly one instruction retires before HALT.
REQ-023 HALT: halted=1, busy=0; start=1 -> FETCH and clears halted and illegal.
REQ-024 busy=1 in FETCH, DECODE, EXECUTE, MEM, WRITEBACK; 0 elsewhere.
REQ-025 instr_cnt SHALL wrap from 32'hFFFF_FFFF to 0 without side effect.
REQ-026 state encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6; 7 is unreachable and SHALL recover to IDLE.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, all outputs 0, instr_cnt=0, and clear the halt-pending flag, including mid-MEM or mid-WRITEBACK, with no write strobe surviving.
REQ-028 The first state change after rst_n deasserts SHALL occur no earlier than the first rising clk edge.

Configuration
REQ-029 Macro SEQ_SINGLE_STEP_EN defined: adds port step_mode  in  1; with step_mode=1, every WRITEBACK goes to HALT, and start executes exactly one further instruction.
REQ-030 SEQ_SINGLE_STEP_EN undefined: no step_mode port; behaviour is identical to step_mode=0.

Verification
REQ-031 Reset, start=1, imem_rdy=1, opcode=OPCODE_I_TYPE for 3 instructions -> pc_wr_en pulses every 4 cycles; instr_cnt=3.
REQ-032 Store (7'b0100011) with cu_data_mem_wr_en=1 and dmem_rdy delayed 3 cycles -> data_mem_wr_en high 4 cycles; WRITEBACK at cycle 8; prf_wr_en=cu_prf_wr_en.
REQ-033 opcode=7'b1111111 -> HALT after DECODE; illegal=1, instr_cnt unchanged, no write strobe; start -> illegal=0.
REQ-034 halt_req pulsed during DECODE -> current instruction retires, then HALT; start with no halt_req -> continues fetching.
REQ-035 rst_n dropped during MEM with data_mem_wr_en=1 -> data_mem_wr_en=0 without waiting for clk; state=0, instr_cnt=0.
REQ-036 instr_cnt preloaded to 32'hFFFF_FFFF via forced retirements, one more B_TYPE with branch_taken=1 -> pc_sel_branch=1 in WRITEBACK; instr_cnt=0.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with halt and illegal-opcode stop.
// Optional feature: define SEQ_SINGLE_STEP_EN to add step_mode (halt after every retired instruction).
module core_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic [6:0]  opcode,
    input  logic        imem_rdy,
    input  logic        dmem_rdy,
    input  logic        cu_prf_wr_en,
    input  logic        cu_data_mem_wr_en,
    input  logic        branch_taken,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic        step_mode,
`endif
    output logic        imem_req,
    output logic        ir_ld,
    output logic        dmem_req,
    output logic        prf_wr_en,
    output logic        data_mem_wr_en,
    output logic        pc_wr_en,
    output logic        pc_sel_branch,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instr_cnt
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEM       = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_HALT      = 3'd6;

    localparam logic [6:0] OPCODE_I_TYPE = 7'b0010011;
    localparam logic [6:0] OPCODE_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPCODE_B_TYPE = 7'b1100011;
    localparam logic [6:0] OPCODE_J_TYPE = 7'b1101111;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;

    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic        halt_pend_q;
    logic        halt_pend_d;
    logic        illegal_q;
    logic        illegal_d;
    logic [31:0] instr_cnt_q;
    logic        step_halt;
    logic        running;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OPCODE_I_TYPE, OPCODE_R_TYPE, OPCODE_B_TYPE, OPCODE_J_TYPE,
            OPCODE_LOAD, OPCODE_STORE: is_legal = 1'b1;
            default:                   is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        is_mem = (op == OPCODE_LOAD) || (op == OPCODE_STORE);
    endfunction

`ifdef SEQ_SINGLE_STEP_EN
    assign step_halt = step_mode;
`else
    assign step_halt = 1'b0;
`endif

    assign running = (state_q >= S_FETCH) && (state_q <= S_WRITEBACK);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_FETCH;
            S_FETCH:     if (imem_rdy) state_d = S_DECODE;
            S_DECODE:    state_d = is_legal(opcode) ? S_EXECUTE : S_HALT;
            S_EXECUTE:   state_d = is_mem(opcode) ? S_MEM : S_WRITEBACK;
            S_MEM:       if (dmem_rdy) state_d = S_WRITEBACK;
            S_WRITEBACK: state_d = (halt_pend_q || halt_req || step_halt) ? S_HALT : S_FETCH;
            S_HALT:      if (start) state_d = S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    // Start and halt_req together in IDLE still latch the request so one instruction retires first.
    always_comb begin
        halt_pend_d = halt_pend_q;
        if ((running && halt_req) || (state_q == S_IDLE && start && halt_req))
            halt_pend_d = 1'b1;
        if (state_d == S_HALT && state_q != S_HALT)
            halt_pend_d = 1'b0;
    end

    always_comb begin
        illegal_d = illegal_q;
        if (state_q == S_DECODE && !is_legal(opcode))
            illegal_d = 1'b1;
        else if (state_q == S_HALT && start)
            illegal_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            halt_pend_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            illegal_q   <= illegal_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instr_cnt_q <= 32'd0;
        else if (state_q == S_WRITEBACK)
            instr_cnt_q <= instr_cnt_q + 32'd1;
    end

    // Strobes decode from the registered state, so an async reset drops them without a clock.
    always_comb begin
        imem_req       = 1'b0;
        ir_ld          = 1'b0;
        dmem_req       = 1'b0;
        prf_wr_en      = 1'b0;
        data_mem_wr_en = 1'b0;
        pc_wr_en       = 1'b0;
        pc_sel_branch  = 1'b0;
        busy           = 1'b0;
        halted         = 1'b0;
        case (state_q)
            S_FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                ir_ld    = imem_rdy;
            end
            S_DECODE, S_EXECUTE: busy = 1'b1;
            S_MEM: begin
                busy           = 1'b1;
                dmem_req       = 1'b1;
                data_mem_wr_en = cu_data_mem_wr_en;
            end
            S_WRITEBACK: begin
                busy          = 1'b1;
                prf_wr_en     = cu_prf_wr_en;
                pc_wr_en      = 1'b1;
                pc_sel_branch = branch_taken;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign illegal   = illegal_q;
    assign state     = state_q;
    assign instr_cnt = instr_cnt_q;

endmodule
